// File: rtl/muldiv_unit_pkg.sv
// Shared CPU definitions for the HI/LO multiply/divide unit: op encoding, FSM states,
// divide constants and a magnitude helper.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5
  } muldiv_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } muldiv_state_t;

  localparam int unsigned DIV_ITERS = 32;
  localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic        flush;
  logic        op_valid;
  muldiv_op_t  op;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic [63:0] hilo_value;
  logic        busy;
  logic        hilo_wen;
  logic [63:0] hilo_result;

  modport master (
    output flush, op_valid, op, rs_value, rt_value, hilo_value,
    input  busy, hilo_wen, hilo_result
  );

  modport slave (
    input  flush, op_valid, op, rs_value, rt_value, hilo_value,
    output busy, hilo_wen, hilo_result
  );

endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Restoring radix-2 divider datapath on unsigned magnitudes; one quotient bit per step.
module div_iter
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        last_o
);

  localparam int unsigned CntW = $clog2(DIV_ITERS);

  logic [31:0]     rem_q, rem_d;
  logic [31:0]     quo_q, quo_d;
  logic [31:0]     dvsr_q, dvsr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [32:0] partial;
  logic        fits;

  // Partial remainder may reach 33 bits before the trial subtract; the result always fits in 32.
  assign partial = {rem_q, quo_q[31]};
  assign fits    = partial >= {1'b0, dvsr_q};

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      rem_d  = '0;
      quo_d  = '0;
      dvsr_d = '0;
      cnt_d  = '0;
    end else if (load_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      dvsr_d = divisor_i;
      cnt_d  = CntW'(DIV_ITERS - 1);
    end else if (step_i) begin
      rem_d = fits ? (partial[31:0] - dvsr_q) : partial[31:0];
      quo_d = {quo_q[30:0], fits};
      cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign last_o      = (cnt_q == '0);

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: 2-cycle multiply, 34-cycle signed/unsigned divide,
// single-cycle MTHI/MTLO and divide-by-zero, with pipeline flush support.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  muldiv_state_t state_q, state_d;
  logic [32:0]   mul_a_q, mul_a_d;
  logic [32:0]   mul_b_q, mul_b_d;
  logic [63:0]   result_q, result_d;
  logic          quo_neg_q, quo_neg_d;
  logic          rem_neg_q, rem_neg_d;

  logic        div_load, div_step, div_clear, div_last;
  logic [31:0] div_dividend, div_divisor, div_quo, div_rem;
  logic        is_mul, is_div, is_signed, div_zero;
  logic [63:0] mul_a_ext, mul_b_ext, product;

  assign is_mul    = (bus.op == OpMult) || (bus.op == OpMultu);
  assign is_div    = (bus.op == OpDiv) || (bus.op == OpDivu);
  assign is_signed = (bus.op == OpMult) || (bus.op == OpDiv);
  assign div_zero  = (bus.rt_value == '0);

  assign div_dividend = is_signed ? abs32(bus.rs_value) : bus.rs_value;
  assign div_divisor  = is_signed ? abs32(bus.rt_value) : bus.rt_value;

  // 33x33 signed product; the low 64 bits are exact for both signed and unsigned operands.
  assign mul_a_ext = {{31{mul_a_q[32]}}, mul_a_q};
  assign mul_b_ext = {{31{mul_b_q[32]}}, mul_b_q};
  assign product   = mul_a_ext * mul_b_ext;

  div_iter u_div_iter (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (div_clear),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (div_dividend),
    .divisor_i   (div_divisor),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .last_o      (div_last)
  );

  always_comb begin
    state_d         = state_q;
    mul_a_d         = mul_a_q;
    mul_b_d         = mul_b_q;
    result_d        = result_q;
    quo_neg_d       = quo_neg_q;
    rem_neg_d       = rem_neg_q;
    div_load        = 1'b0;
    div_step        = 1'b0;
    div_clear       = bus.flush;
    bus.busy        = 1'b0;
    bus.hilo_wen    = 1'b0;
    bus.hilo_result = '0;

    unique case (state_q)
      StIdle: begin
        bus.busy = bus.op_valid & ~bus.flush & (is_mul | (is_div & ~div_zero));
        if (bus.op_valid && !bus.flush) begin
          unique case (bus.op)
            OpMult, OpMultu: begin
              mul_a_d = {is_signed & bus.rs_value[31], bus.rs_value};
              mul_b_d = {is_signed & bus.rt_value[31], bus.rt_value};
              state_d = StMul;
            end
            OpDiv, OpDivu: begin
              if (div_zero) begin
                result_d = {bus.rs_value, DIV0_LO};
                state_d  = StDone;
              end else begin
                div_load  = 1'b1;
                quo_neg_d = is_signed & (bus.rs_value[31] ^ bus.rt_value[31]);
                rem_neg_d = is_signed & bus.rs_value[31];
                state_d   = StDiv;
              end
            end
            OpMthi: begin
              result_d = {bus.rs_value, bus.hilo_value[31:0]};
              state_d  = StDone;
            end
            OpMtlo: begin
              result_d = {bus.hilo_value[63:32], bus.rs_value};
              state_d  = StDone;
            end
            default: ;
          endcase
        end
      end
      StMul: begin
        bus.busy = 1'b1;
        result_d = product;
        state_d  = StDone;
      end
      StDiv: begin
        bus.busy = 1'b1;
        div_step = 1'b1;
        if (div_last) state_d = StFix;
      end
      StFix: begin
        bus.busy = 1'b1;
        result_d = {rem_neg_q ? -div_rem : div_rem, quo_neg_q ? -div_quo : div_quo};
        state_d  = StDone;
      end
      StDone: begin
        bus.hilo_wen    = ~bus.flush;
        bus.hilo_result = bus.flush ? '0 : result_q;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bus.flush) begin
      state_d   = StIdle;
      mul_a_d   = '0;
      mul_b_d   = '0;
      result_d  = '0;
      quo_neg_d = 1'b0;
      rem_neg_d = 1'b0;
    end

    // Outputs stay quiet for the whole reset window, including before the first edge.
    if (rst) begin
      bus.busy        = 1'b0;
      bus.hilo_wen    = 1'b0;
      bus.hilo_result = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      result_q  <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      result_q  <= result_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

endmodule
